// File: rtl/cdc_sync_filt.sv
// cdc_sync_filt
//   Multi-channel single-bit clock-domain-crossing synchronizer with a
//   stability (debounce) filter and registered edge pulses.
//
//   Each channel passes through an N-flop synchronizer. The synchronized
//   value must then differ from the accepted output for FILT consecutive
//   cycles before it is accepted onto dout. The acceptance edge also
//   produces a one-cycle rise or fall pulse.
//
// Parameters
//   CH   : number of independent channels
//   N    : synchronizer stages per channel (>= 2)
//   FILT : consecutive stable cycles required (>= 1, 1 = no filtering)
//   INIT : reset value of synchronizer stages and dout
//
// Ports
//   clk  : in  1   single clock, all state on posedge
//   rst  : in  1   synchronous reset, active-high
//   din  : in  CH  asynchronous level inputs
//   dout : out CH  filtered, synchronized levels (registered)
//   rise : out CH  one-cycle pulse when dout goes 0->1 (registered)
//   fall : out CH  one-cycle pulse when dout goes 1->0 (registered)
//
// Optional build macro
//   CDC_SYNC_META_EMU_EN : in simulation (SYNTHESIS undefined) the filter
//   input of each bit is picked at random every cycle from the last or the
//   second-to-last synchronizer stage, emulating one cycle of metastability
//   resolution uncertainty. Otherwise the last stage is always used.

module cdc_sync_filt #(
  parameter int            CH   = 4,
  parameter int            N    = 2,
  parameter int            FILT = 4,
  parameter logic [CH-1:0] INIT = {CH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] dout,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  localparam int            CW      = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

  if (N < 2 || FILT < 1) begin : g_bad_param
    $error("cdc_sync_filt: N must be >= 2 and FILT must be >= 1");
  end

  logic [CH-1:0] r_sync [N];
  logic [CH-1:0] w_sv;

  // Synchronizer chain: stage 0 captures the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) r_sync[k] <= INIT;
    end else begin
      r_sync[0] <= din;
      for (int k = 1; k < N; k++) r_sync[k] <= r_sync[k-1];
    end
  end

`ifdef CDC_SYNC_META_EMU_EN
`ifndef SYNTHESIS
  // Random per-bit selector, refreshed every cycle; 1 picks the earlier stage
  logic [CH-1:0] r_pick;

  always_ff @(posedge clk) begin
    r_pick <= CH'($urandom);
  end

  assign w_sv = (r_pick & r_sync[N-2]) | (~r_pick & r_sync[N-1]);
`else
  assign w_sv = r_sync[N-1];
`endif
`else
  assign w_sv = r_sync[N-1];
`endif

  // Stability filter and edge pulses, one independent instance per channel
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic          r_dout;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_dout <= INIT[i];
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        if (w_sv[i] == r_dout) begin
          // Any agreement restarts the stability count
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_dout <= w_sv[i];
          r_rise <= w_sv[i];
          r_fall <= ~w_sv[i];
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign dout[i] = r_dout;
    assign rise[i] = r_rise;
    assign fall[i] = r_fall;
  end

endmodule

// File: tb/tb_cdc_sync_filt.sv
// Directed testbench for cdc_sync_filt with CH=4, N=2, FILT=4, INIT=0.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, so each check reflects the edge that just occurred.

module tb_cdc_sync_filt;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] rise;
  logic [3:0] fall;

  int checks = 0;
  int errors = 0;

  cdc_sync_filt #(
    .CH  (4),
    .N   (2),
    .FILT(4),
    .INIT(4'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(dout),
    .rise(rise),
    .fall(fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] ed, input logic [3:0] er,
                     input logic [3:0] ef);
    checks++;
    assert ({dout, rise, fall} === {ed, er, ef}) else begin
      errors++;
      $error("FAIL %s observed dout=%h rise=%h fall=%h expected dout=%h rise=%h fall=%h",
             tag, dout, rise, fall, ed, er, ef);
    end
  endtask

  // n quiet edges holding d0, then one edge where dout becomes d1 with pulses
  task automatic expect_after(input string tag, input int n, input logic [3:0] d0,
                              input logic [3:0] d1, input logic [3:0] r,
                              input logic [3:0] f);
    for (int j = 0; j < n; j++) begin
      tick();
      chk({tag, "_hold"}, d0, 4'h0, 4'h0);
    end
    tick();
    chk({tag, "_update"}, d1, r, f);
    tick();
    chk({tag, "_after"}, d1, 4'h0, 4'h0);
  endtask

  initial begin
    rst = 1'b1;
    din = 4'hF;

    // Reset for 3 edges with all inputs high; outputs stay at INIT
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("reset", 4'h0, 4'h0, 4'h0);
    end
    rst = 1'b0;
    // First sampling edge r+1, acceptance at r+6
    expect_after("post_reset_rise", 5, 4'h0, 4'hF, 4'hF, 4'h0);

    // Return all channels low
    din = 4'h0;
    expect_after("all_fall", 5, 4'hF, 4'h0, 4'h0, 4'hF);

    // 3-cycle pulse is shorter than FILT and must be rejected
    din = 4'h1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("short_pulse_hi", 4'h0, 4'h0, 4'h0);
    end
    din = 4'h0;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("short_pulse_lo", 4'h0, 4'h0, 4'h0);
    end

    // Exactly FILT-cycle pulse is accepted and reproduced with equal width
    din = 4'h1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("pulse4_sample", 4'h0, 4'h0, 4'h0);
    end
    din = 4'h0;
    tick();
    chk("pulse4_pre", 4'h0, 4'h0, 4'h0);
    tick();
    chk("pulse4_rise", 4'h1, 4'h1, 4'h0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("pulse4_high", 4'h1, 4'h0, 4'h0);
    end
    tick();
    chk("pulse4_fall", 4'h0, 4'h0, 4'h1);
    tick();
    chk("pulse4_idle", 4'h0, 4'h0, 4'h0);

    // Simultaneous rise and fall on different channels
    din = 4'b0100;
    expect_after("set_0100", 5, 4'h0, 4'b0100, 4'b0100, 4'b0000);
    din = 4'b0010;
    expect_after("swap", 5, 4'b0100, 4'b0010, 4'b0010, 4'b0100);
    din = 4'h0;
    expect_after("clear", 5, 4'b0010, 4'h0, 4'h0, 4'b0010);

    // Reset mid-count: count and synchronizer are discarded, no pulse
    din = 4'h8;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("midcount_run", 4'h0, 4'h0, 4'h0);
    end
    rst = 1'b1;
    tick();
    chk("midcount_reset", 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    expect_after("midcount_relatch", 5, 4'h0, 4'h8, 4'h8, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_sync_filt.md
CDC_SYNC_FILT -- requirements
Module: cdc_sync_filt

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent single-bit channels.
REQ-002 SHALL have parameter N, default 2: synchronizer stages per channel, minimum 2.
REQ-003 SHALL have parameter FILT, default 4: consecutive cycles the synchronized value must be stable before acceptance, minimum 1; FILT=1 disables filtering.
REQ-004 SHALL have parameter INIT, default {CH{1'b0}}: reset value of the synchronizer stages and dout.
REQ-005 SHALL have port clk  input  1  clock; the only clock; all state on posedge clk.
REQ-006 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-007 SHALL have port din  input  CH  asynchronous level inputs.
REQ-008 SHALL have port dout  output  CH  filtered, synchronized levels, registered.
REQ-009 SHALL have port rise  output  CH  one-cycle pulse on dout 0->1, registered.
REQ-010 SHALL have port fall  output  CH  one-cycle pulse on dout 1->0, registered.

Function
REQ-011 Per channel, SHALL implement an N-flop chain s[0..N-1] with s[0]<=din[i] and s[k]<=s[k-1].
REQ-012 Filter input SHALL be sv=s[N-1], except as modified by REQ-026.
REQ-013 Per channel, SHALL keep counter cnt, width max(1,$clog2(FILT)), reset 0.
REQ-014 sv==dout: cnt<=0, dout holds.
REQ-015 sv!=dout and cnt<FILT-1: cnt<=cnt+1, dout holds.
REQ-016 sv!=dout and cnt==FILT-1: dout<=sv, cnt<=0; with FILT=1 dout follows sv on the first mismatch edge.
REQ-017 cnt SHALL never exceed FILT-1 and SHALL never wrap.
REQ-018 Latency: din stable from sampling edge k onward -> dout updates at edge k+N+FILT-1.
REQ-019 A level held at sv for fewer than FILT consecutive cycles SHALL be rejected, with no change on dout, rise or fall.
REQ-020 rise[i]/fall[i] SHALL assert on the same edge as the dout[i] update, for exactly one cycle; both outputs SHALL otherwise be 0.
REQ-021 Channels SHALL be fully independent; simultaneous updates on different channels each produce their own pulse on the same edge.
REQ-022 N<2 or FILT<1 SHALL cause an elaboration error.

Reset
REQ-023 While rst=1 at a clk edge: all s stages<=INIT, dout<=INIT, cnt<=0, rise<=0, fall<=0.
REQ-024 Reset SHALL take priority over every other update, including mid-count; no pulse SHALL be generated by reset entry or exit.
REQ-025 After release with din!=INIT, dout SHALL update only after the full REQ-018 latency, counted from the first post-reset sampling edge.

Configuration
REQ-026 Macro CDC_SYNC_META_EMU_EN, when defined and SYNTHESIS undefined: sv per bit SHALL be chosen at random each cycle from s[N-2] or s[N-1], emulating one cycle of metastability uncertainty. Macro undefined, or SYNTHESIS defined: sv=s[N-1], fully deterministic.
REQ-027 With emulation active, REQ-018 latency SHALL become k+N+FILT-2 or k+N+FILT-1; REQ-019 rejection SHALL still hold for pulses shorter than FILT-1 cycles.

Verification (CH=4, N=2, FILT=4, INIT=0, macro undefined unless stated)
REQ-028 Apply rst=1 for 3 cycles with din=4'hF; release at edge r; hold din -> dout=0 and rise=fall=0 during reset; first sampling edge is r+1; dout=4'hF and rise=4'hF at edge r+6 only.
REQ-029 Drive din[0] high for 3 cycles, then low -> dout[0], rise[0] and fall[0] stay 0 throughout.
REQ-030 Drive din[0] high for exactly 4 cycles -> dout[0] high for 4 cycles; rise[0] at edge k+5; fall[0] 4 cycles later.
REQ-031 With dout=4'b0100, drive din=4'b0010 in one cycle -> on the same edge rise=4'b0010, fall=4'b0100, dout=4'b0010.
REQ-032 Hold din[3]=1 long enough for cnt to reach 2, then assert rst for 1 cycle -> dout=0, cnt=0, no pulse; after release, dout[3] rises at the full REQ-018 latency.
REQ-033 Define CDC_SYNC_META_EMU_EN and run 1000 random toggles of din with 10-cycle hold each -> every update lands at k+4 or k+5; no update occurs for holds of 2 cycles or less.
